// File: rtl/spi_pkg.sv
// Shared SPI definitions: frame width, idle fill word, FSM encoding, select codes.
// Imported by the slave, its shift register, and the master side.
// No logic; constants and types only.
package spi_pkg;

    localparam int         SPI_DATA_W    = 8;
    localparam logic [7:0] SPI_IDLE_FILL = 8'h00;

    localparam logic ST_IDLE   = 1'b0;
    localparam logic ST_ACTIVE = 1'b1;

    typedef enum logic {
        IDLE   = ST_IDLE,
        ACTIVE = ST_ACTIVE
    } spi_state_e;

    // Slave-select codes, common to master and slaves
    localparam logic [1:0] S1 = 2'd0;
    localparam logic [1:0] S2 = 2'd1;
    localparam logic [1:0] S3 = 2'd2;
    localparam logic [1:0] S4 = 2'd3;

endpackage

// File: rtl/spi_shift_reg.sv
// Parametrised shift register with parallel load, serial shift and fixed direction.
// Latency: load/shift visible one cycle after the edge; load has priority over shift.
// No backpressure: acts on load_i/shift_i every enabled edge.
module spi_shift_reg
    import spi_pkg::*;
#(
    parameter int             W         = SPI_DATA_W,
    parameter bit             LSB_FIRST = 1'b0,
    parameter logic [W-1:0]   RST_VAL   = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_dat_i,
    input  logic         shift_i,
    input  logic         ser_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (load_i) begin
            q_d = load_dat_i;
        end else if (shift_i) begin
            // LSB-first shifts toward bit 0 so q[0] is the next bit out
            q_d = LSB_FIRST ? {ser_i, q_q[W-1:1]} : {q_q[W-2:0], ser_i};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= RST_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/spi_slave.sv
// SPI slave: MOSI deserialised MSB-first into rx_data, tx byte serialised LSB-first on MISO.
// Latency: rx_valid one cycle after the edge sampling the last MOSI bit; MISO registered.
// tx side has a 1-deep pending buffer (tx_ready low while full); rx never stalls, newest wins.
module spi_slave
    import spi_pkg::*;
#(
    parameter int                DATA_W    = SPI_DATA_W,
    parameter logic [DATA_W-1:0] IDLE_FILL = DATA_W'(SPI_IDLE_FILL)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              SS,
    input  logic              MOSI,
    output logic              MISO,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              rx_overrun,
    input  logic              rx_ack,
    output logic              frame_err
);

    localparam int              CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    spi_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] pend_q, pend_d;
    logic              pend_full_q, pend_full_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              rx_overrun_q, rx_overrun_d;
    logic              frame_err_q, frame_err_d;
    logic              rx_full_q, rx_full_d;

    logic              tx_load, tx_shift_en, rx_shift_en;
    logic [DATA_W-1:0] tx_load_dat;
    logic [DATA_W-1:0] tx_q, rx_q;
    logic [DATA_W-1:0] rx_word;
    logic              tx_fire, eff_full, reload, drain;
    logic [DATA_W-1:0] eff_dat;
    logic              unused_bits;

    assign tx_ready = !pend_full_q;
    assign tx_fire  = tx_valid && tx_ready;
    // A word accepted this cycle may bypass the buffer when a load point coincides
    assign eff_full = pend_full_q || tx_fire;
    assign eff_dat  = pend_full_q ? pend_q : tx_data;
    assign rx_word  = {rx_q[DATA_W-2:0], MOSI};

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pend_d       = pend_q;
        pend_full_d  = pend_full_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = 1'b0;
        rx_overrun_d = 1'b0;
        frame_err_d  = 1'b0;
        rx_full_d    = rx_ack ? 1'b0 : rx_full_q;
        tx_load      = 1'b0;
        tx_load_dat  = IDLE_FILL;
        tx_shift_en  = 1'b0;
        rx_shift_en  = 1'b0;
        reload       = 1'b0;
        drain        = 1'b0;

        if (SS) begin
            // Every edge with SS high is a data edge, including the IDLE->ACTIVE one
            state_d     = ACTIVE;
            tx_shift_en = 1'b1;
            rx_shift_en = 1'b1;
            cnt_d       = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
                cnt_d        = '0;
                rx_data_d    = rx_word;
                rx_valid_d   = 1'b1;
                rx_overrun_d = rx_full_q && !rx_ack;
                rx_full_d    = 1'b1;
                reload       = 1'b1;
            end
        end else begin
            state_d = IDLE;
            if (state_q == ACTIVE && cnt_q != '0) begin
                frame_err_d = 1'b1;
                cnt_d       = '0;
                reload      = 1'b1;
            end else begin
                drain = 1'b1;
            end
        end

        if ((reload || drain) && eff_full) begin
            tx_load     = 1'b1;
            tx_load_dat = eff_dat;
            pend_full_d = 1'b0;
        end else if (reload) begin
            tx_load     = 1'b1;
            tx_load_dat = IDLE_FILL;
        end else if (tx_fire) begin
            pend_full_d = 1'b1;
            pend_d      = tx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            pend_q       <= '0;
            pend_full_q  <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            rx_overrun_q <= 1'b0;
            frame_err_q  <= 1'b0;
            rx_full_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pend_q       <= pend_d;
            pend_full_q  <= pend_full_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            rx_overrun_q <= rx_overrun_d;
            frame_err_q  <= frame_err_d;
            rx_full_q    <= rx_full_d;
        end
    end

    spi_shift_reg #(
        .W         (DATA_W),
        .LSB_FIRST (1'b1),
        .RST_VAL   (IDLE_FILL)
    ) u_tx_shift (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tx_load),
        .load_dat_i (tx_load_dat),
        .shift_i    (tx_shift_en),
        .ser_i      (1'b0),
        .q_o        (tx_q)
    );

    spi_shift_reg #(
        .W         (DATA_W),
        .LSB_FIRST (1'b0),
        .RST_VAL   ('0)
    ) u_rx_shift (
        .clk        (clk),
        .rst        (rst),
        .load_i     (1'b0),
        .load_dat_i ('0),
        .shift_i    (rx_shift_en),
        .ser_i      (MOSI),
        .q_o        (rx_q)
    );

    assign unused_bits = ^{tx_q[DATA_W-1:1], rx_q[DATA_W-1]};

    assign MISO       = tx_q[0];
    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign rx_overrun = rx_overrun_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: rx bytes scoreboarded through a queue, MISO/tx_ready/pulses checked inline.
module tb_spi_slave;

    logic       clk = 1'b0;
    logic       rst, SS, MOSI, MISO;
    logic [7:0] tx_data;
    logic       tx_valid, tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid, rx_overrun, rx_ack, frame_err;

    int         n_assert = 0;
    int         n_fail   = 0;
    int         bits     = 0;
    logic       full_m   = 1'b0;
    logic [7:0] shifted  = 8'h00;
    logic [7:0] rxq[$];

    always #5 clk = ~clk;

    spi_slave #(.DATA_W(8), .IDLE_FILL(8'h00)) dut (
        .clk        (clk),
        .rst        (rst),
        .SS         (SS),
        .MOSI       (MOSI),
        .MISO       (MISO),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_overrun (rx_overrun),
        .rx_ack     (rx_ack),
        .frame_err  (frame_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: model expected pulses from the inputs being driven, push rx bytes, then check.
    task automatic tick();
        logic exp_v, exp_fe, exp_ov, done;
        exp_v = 1'b0; exp_fe = 1'b0; exp_ov = 1'b0; done = 1'b0;
        if (rst) begin
            bits   = 0;
            full_m = 1'b0;
        end else if (SS) begin
            shifted = {shifted[6:0], MOSI};
            bits++;
            if (bits == 8) begin
                done   = 1'b1;
                bits   = 0;
                exp_v  = 1'b1;
                exp_ov = full_m && !rx_ack;
                rxq.push_back(shifted);
            end
        end else begin
            exp_fe = (bits != 0);
            bits   = 0;
        end
        if (!rst) full_m = done ? 1'b1 : (rx_ack ? 1'b0 : full_m);
        @(posedge clk);
        #1;
        chk("rx_valid", rx_valid, exp_v);
        chk("frame_err", frame_err, exp_fe);
        chk("rx_overrun", rx_overrun, exp_ov);
        if (rx_valid === 1'b1 && rxq.size() > 0) chk("rx_data", rx_data, rxq.pop_front());
    endtask

    task automatic frame(input logic [7:0] b, input int nbits, input logic chk_m,
                         input logic [7:0] m, input int load_at, input logic [7:0] ld);
        for (int i = 0; i < nbits; i++) begin
            SS   = 1'b1;
            MOSI = b[7-i];
            if (i == load_at) begin
                tx_valid = 1'b1;
                tx_data  = ld;
            end
            if (chk_m) chk("miso_bit", MISO, m[i]);
            tick();
            if (i == load_at) begin
                tx_valid = 1'b0;
                chk("tx_ready_mid", tx_ready, 0);
            end
        end
    endtask

    task automatic idle();
        SS   = 1'b0;
        MOSI = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b1; SS = 1'b0; MOSI = 1'b0;
        tx_data = 8'h00; tx_valid = 1'b0; rx_ack = 1'b1;
        tick();
        chk("rst_rx_data", rx_data, 8'h00);
        chk("rst_miso", MISO, 0);
        chk("rst_tx_ready", tx_ready, 1);
        rst = 1'b0;
        idle();

        // Write byte A5
        frame(8'hA5, 8, 1'b0, 8'h00, -1, 8'h00);
        idle();

        // Read byte 3C loaded in IDLE: accepted and drained in one cycle
        tx_data = 8'h3C; tx_valid = 1'b1;
        chk("tx_ready_idle", tx_ready, 1);
        idle();
        tx_valid = 1'b0;
        chk("tx_ready_after_load", tx_ready, 1);
        frame(8'h00, 8, 1'b1, 8'h3C, -1, 8'h00);
        idle();
        chk("miso_idle_fill", MISO, 0);

        // Back-to-back 12,34 with F0 queued mid first byte
        frame(8'h12, 8, 1'b1, 8'h00, 3, 8'hF0);
        chk("tx_ready_drained", tx_ready, 1);
        frame(8'h34, 8, 1'b1, 8'hF0, -1, 8'h00);
        idle();

        // Abort after 5 bits, then a clean 81
        frame(8'hFF, 5, 1'b0, 8'h00, -1, 8'h00);
        idle();
        chk("abort_rx_data_held", rx_data, 8'h34);
        frame(8'h81, 8, 1'b0, 8'h00, -1, 8'h00);
        idle();

        // Overrun without ack, then none with ack
        rx_ack = 1'b0;
        frame(8'h55, 8, 1'b0, 8'h00, -1, 8'h00);
        idle();
        frame(8'hAA, 8, 1'b0, 8'h00, -1, 8'h00);
        idle();
        rx_ack = 1'b1;
        idle();
        frame(8'h66, 8, 1'b0, 8'h00, -1, 8'h00);
        idle();
        frame(8'h77, 8, 1'b0, 8'h00, -1, 8'h00);
        idle();

        // Reset mid-frame with a pending tx word
        frame(8'hC3, 3, 1'b0, 8'h00, 1, 8'hFF);
        rst = 1'b1;
        tick();
        chk("rst_mid_rx_data", rx_data, 8'h00);
        chk("rst_mid_miso", MISO, 0);
        chk("rst_mid_tx_ready", tx_ready, 1);
        rst = 1'b0;
        idle();
        chk("post_rst_miso", MISO, 0);
        frame(8'h5A, 8, 1'b1, 8'h00, -1, 8'h00);
        idle();
        chk("rxq_drained", rxq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
